// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: write-back source encodings, datapath and
// register index widths, and the hard-wired zero register index.
package rv_pipe_pkg;
    localparam int RV_XLEN = 32;
    localparam int REG_AW  = 5;

    localparam logic [REG_AW-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_PC   = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;
endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB slot, ID read ports and EX forwarding tap of the write-back stage.
interface writeback_regfile_if
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int AW    = REG_AW,
    parameter int CNT_W = 64
);
    logic             BUSY_WAIT;
    logic             WB_VALID;
    logic             REG_WRITE;
    logic [1:0]       MEM_TO_REG;
    logic [AW-1:0]    IN_ADDRESS;
    logic [XLEN-1:0]  ALU_RESULT;
    logic [XLEN-1:0]  DATA_READED;
    logic [XLEN-1:0]  PC_NEXT;
    logic [AW-1:0]    RS1_ADDR;
    logic [AW-1:0]    RS2_ADDR;
    logic [XLEN-1:0]  RS1_DATA;
    logic [XLEN-1:0]  RS2_DATA;
    logic [XLEN-1:0]  WB_DATA_OUT;
    logic             WB_EN_OUT;
    logic [AW-1:0]    WB_ADDR_OUT;
    logic [CNT_W-1:0] INSTRET_OUT;

    modport master (
        output BUSY_WAIT, WB_VALID, REG_WRITE, MEM_TO_REG, IN_ADDRESS,
               ALU_RESULT, DATA_READED, PC_NEXT, RS1_ADDR, RS2_ADDR,
        input  RS1_DATA, RS2_DATA, WB_DATA_OUT, WB_EN_OUT, WB_ADDR_OUT,
               INSTRET_OUT
    );

    modport slave (
        input  BUSY_WAIT, WB_VALID, REG_WRITE, MEM_TO_REG, IN_ADDRESS,
               ALU_RESULT, DATA_READED, PC_NEXT, RS1_ADDR, RS2_ADDR,
        output RS1_DATA, RS2_DATA, WB_DATA_OUT, WB_EN_OUT, WB_ADDR_OUT,
               INSTRET_OUT
    );
endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file: one write port, two combinational read ports with
// write-through bypass, x0 hard-wired to zero, asynchronous clear.
module regfile_2r1w
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            WE,
    input  logic [AW-1:0]   WADDR,
    input  logic [XLEN-1:0] WDATA,
    input  logic [AW-1:0]   RADDR1,
    input  logic [AW-1:0]   RADDR2,
    output logic [XLEN-1:0] RDATA1,
    output logic [XLEN-1:0] RDATA2
);
    logic [NREGS-1:0][XLEN-1:0] regs;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            regs <= '0;
        end else if (WE && WADDR != AW'(REG_X0)) begin
            regs[WADDR] <= WDATA;
        end
    end

    // The value about to be committed is visible in the same cycle, so ID
    // never sees a stale operand for the instruction retiring now.
    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
        if (a == AW'(REG_X0))
            return '0;
        if (WE && a == WADDR)
            return WDATA;
        return regs[a];
    endfunction

    always_comb begin
        RDATA1 = rd_port(RADDR1);
        RDATA2 = rd_port(RADDR2);
    end
endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage: result select, qualified commit into the register file,
// forwarding tap and retired-instruction counter.
module writeback_regfile
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 64,
    localparam int AW   = $clog2(NREGS)
) (
    input logic               CLK,
    input logic               RESET,
    writeback_regfile_if.slave bus
);
    logic [XLEN-1:0]  wb_data;
    logic             wb_en;
    logic [CNT_W-1:0] instret;

    always_comb begin
        case (wb_sel_e'(bus.MEM_TO_REG))
            WB_SEL_MEM: wb_data = bus.DATA_READED;
            WB_SEL_PC:  wb_data = bus.PC_NEXT;
            default:    wb_data = bus.ALU_RESULT;
        endcase
    end

    // Gated by reset so the bypass never shows a value the array will not hold.
    assign wb_en = RESET & bus.WB_VALID & bus.REG_WRITE & ~bus.BUSY_WAIT
                 & (bus.IN_ADDRESS != AW'(REG_X0));

    regfile_2r1w #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .CLK    (CLK),
        .RESET  (RESET),
        .WE     (wb_en),
        .WADDR  (bus.IN_ADDRESS),
        .WDATA  (wb_data),
        .RADDR1 (bus.RS1_ADDR),
        .RADDR2 (bus.RS2_ADDR),
        .RDATA1 (bus.RS1_DATA),
        .RDATA2 (bus.RS2_DATA)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            instret <= '0;
        end else if (bus.WB_VALID && !bus.BUSY_WAIT) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign bus.WB_DATA_OUT = wb_data;
    assign bus.WB_EN_OUT   = wb_en;
    assign bus.WB_ADDR_OUT = bus.IN_ADDRESS;
    assign bus.INSTRET_OUT = instret;
endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vector table, async reset, random
// traffic against an array/counter model, and counter wrap on a narrow copy.
module tb_writeback_regfile;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic RESET_W = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    writeback_regfile_if #(.XLEN(32), .AW(5), .CNT_W(64)) bus ();
    writeback_regfile_if #(.XLEN(32), .AW(5), .CNT_W(4))  wbus ();

    writeback_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );
    writeback_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut_w (
        .CLK(CLK), .RESET(RESET_W), .bus(wbus)
    );

    typedef struct {
        bit        rst, busy, valid, regw;
        bit [1:0]  sel;
        bit [4:0]  rd;
        bit [31:0] alu;
        bit [4:0]  rs1, rs2;
        bit [31:0] e_rs1, e_rs2, e_wb;
        bit        e_en;
        bit [63:0] e_cnt;
    } vec_t;

    vec_t tv[21];

    localparam logic [31:0] MEMV = 32'h22;
    localparam logic [31:0] PCV  = 32'h104;

    logic [31:0] mref [32];
    logic [63:0] mcnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit busy, bit valid, bit regw, bit [1:0] sel,
                                bit [4:0] rd, bit [31:0] alu, bit [4:0] rs1, bit [4:0] rs2,
                                bit [31:0] e1, bit [31:0] e2, bit [31:0] ew, bit een,
                                bit [63:0] ec);
        vec_t v;
        v.rst = rst; v.busy = busy; v.valid = valid; v.regw = regw; v.sel = sel;
        v.rd = rd; v.alu = alu; v.rs1 = rs1; v.rs2 = rs2;
        v.e_rs1 = e1; v.e_rs2 = e2; v.e_wb = ew; v.e_en = een; v.e_cnt = ec;
        return v;
    endfunction

    task automatic drive(input bit busy, input bit valid, input bit regw, input bit [1:0] sel,
                         input bit [4:0] rd, input bit [31:0] alu, input bit [31:0] mem,
                         input bit [31:0] pc, input bit [4:0] rs1, input bit [4:0] rs2);
        bus.BUSY_WAIT   = busy;
        bus.WB_VALID    = valid;
        bus.REG_WRITE   = regw;
        bus.MEM_TO_REG  = sel;
        bus.IN_ADDRESS  = rd;
        bus.ALU_RESULT  = alu;
        bus.DATA_READED = mem;
        bus.PC_NEXT     = pc;
        bus.RS1_ADDR    = rs1;
        bus.RS2_ADDR    = rs2;
    endtask

    // Model read: x0 is zero, a committing write is visible, else stored value.
    function automatic logic [31:0] mread(bit [4:0] a, bit en, bit [4:0] rd, bit [31:0] wbv);
        if (a == 0) return 32'h0;
        if (en && a == rd) return wbv;
        return mref[a];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        bit        busy, valid, regw, en;
        bit [1:0]  sel;
        bit [4:0]  rd, rs1, rs2;
        bit [31:0] alu, mem, pc, wbv;

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wbus.BUSY_WAIT = 0; wbus.WB_VALID = 0; wbus.REG_WRITE = 0; wbus.MEM_TO_REG = 0;
        wbus.IN_ADDRESS = 0; wbus.ALU_RESULT = 0; wbus.DATA_READED = 0; wbus.PC_NEXT = 0;
        wbus.RS1_ADDR = 0; wbus.RS2_ADDR = 0;

        //         rst bsy vld rw sel rd alu           rs1 rs2 e_rs1         e_rs2         e_wb          en cnt
        tv[0]  = mk(0, 0, 1, 1, 0, 5, 32'hDEADBEEF, 5, 0, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0);
        tv[1]  = tv[0];
        tv[2]  = tv[0];
        tv[3]  = mk(1, 0, 1, 1, 0, 5, 32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 0);
        tv[4]  = mk(1, 0, 1, 1, 0, 7, 32'h11,       7, 5, 32'h11,       32'hDEADBEEF, 32'h11,       1, 1);
        tv[5]  = mk(1, 0, 1, 1, 1, 7, 32'h11,       7, 5, 32'h22,       32'hDEADBEEF, 32'h22,       1, 2);
        tv[6]  = mk(1, 0, 1, 1, 2, 7, 32'h11,       7, 5, 32'h104,      32'hDEADBEEF, 32'h104,      1, 3);
        tv[7]  = mk(1, 0, 1, 1, 3, 7, 32'h11,       7, 5, 32'h11,       32'hDEADBEEF, 32'h11,       1, 4);
        tv[8]  = mk(1, 0, 0, 0, 0, 7, 32'h0,        7, 7, 32'h11,       32'h11,       32'h0,        0, 5);
        tv[9]  = mk(1, 0, 1, 1, 0, 3, 32'h5,        3, 3, 32'h5,        32'h5,        32'h5,        1, 5);
        tv[10] = mk(1, 0, 1, 1, 0, 3, 32'hAA,       3, 3, 32'hAA,       32'hAA,       32'hAA,       1, 6);
        tv[11] = mk(1, 0, 0, 0, 0, 3, 32'h0,        3, 3, 32'hAA,       32'hAA,       32'h0,        0, 7);
        tv[12] = mk(1, 0, 1, 1, 0, 0, 32'hFFFFFFFF, 0, 7, 32'h0,        32'h11,       32'hFFFFFFFF, 0, 7);
        tv[13] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 3, 32'h0,        32'hAA,       32'h0,        0, 8);
        tv[14] = mk(1, 1, 1, 1, 0, 9, 32'h1234,     9, 3, 32'h0,        32'hAA,       32'h1234,     0, 8);
        tv[15] = tv[14];
        tv[16] = tv[14];
        tv[17] = tv[14];
        tv[18] = mk(1, 0, 1, 1, 0, 9, 32'h1234,     9, 3, 32'h1234,     32'hAA,       32'h1234,     1, 8);
        tv[19] = mk(1, 0, 0, 1, 0, 9, 32'h5555,     9, 0, 32'h1234,     32'h0,        32'h5555,     0, 9);
        tv[20] = mk(1, 0, 0, 0, 0, 9, 32'h0,        9, 7, 32'h1234,     32'h11,       32'h0,        0, 9);

        for (int i = 0; i < 21; i++) begin
            @(negedge CLK);
            RESET = tv[i].rst;
            drive(tv[i].busy, tv[i].valid, tv[i].regw, tv[i].sel, tv[i].rd, tv[i].alu,
                  MEMV, PCV, tv[i].rs1, tv[i].rs2);
            #1;
            chk($sformatf("vec%0d_rs1", i), bus.RS1_DATA, tv[i].e_rs1);
            chk($sformatf("vec%0d_rs2", i), bus.RS2_DATA, tv[i].e_rs2);
            chk($sformatf("vec%0d_wb", i), bus.WB_DATA_OUT, tv[i].e_wb);
            chk($sformatf("vec%0d_en", i), bus.WB_EN_OUT, tv[i].e_en);
            chk($sformatf("vec%0d_addr", i), bus.WB_ADDR_OUT, tv[i].rd);
            chk($sformatf("vec%0d_instret", i), bus.INSTRET_OUT, tv[i].e_cnt);
        end

        // Asynchronous reset mid-cycle clears storage and counter without an edge.
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 7);
        #1;
        chk("pre_arst_rs1", bus.RS1_DATA, 32'hAA);
        chk("pre_arst_rs2", bus.RS2_DATA, 32'h11);
        #1 RESET = 1'b0;
        #1;
        chk("arst_rs1", bus.RS1_DATA, 32'h0);
        chk("arst_rs2", bus.RS2_DATA, 32'h0);
        chk("arst_instret", bus.INSTRET_OUT, 64'h0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 32; i++) mref[i] = 32'h0;
        mcnt = 64'h0;

        for (int n = 0; n < 400; n++) begin
            @(negedge CLK);
            busy  = ($urandom_range(0, 3) == 0);
            valid = ($urandom_range(0, 3) != 0);
            regw  = ($urandom_range(0, 4) != 0);
            sel   = 2'($urandom_range(0, 3));
            rd    = 5'($urandom_range(0, 31));
            alu   = $urandom;
            mem   = $urandom;
            pc    = $urandom;
            rs1   = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2   = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(busy, valid, regw, sel, rd, alu, mem, pc, rs1, rs2);
            wbv = (sel == 2'd1) ? mem : (sel == 2'd2) ? pc : alu;
            en  = valid && regw && !busy && (rd != 0);
            #1;
            chk("rnd_rs1", bus.RS1_DATA, mread(rs1, en, rd, wbv));
            chk("rnd_rs2", bus.RS2_DATA, mread(rs2, en, rd, wbv));
            chk("rnd_wb", bus.WB_DATA_OUT, wbv);
            chk("rnd_en", bus.WB_EN_OUT, en);
            chk("rnd_addr", bus.WB_ADDR_OUT, rd);
            chk("rnd_instret", bus.INSTRET_OUT, mcnt);
            if (en) mref[rd] = wbv;
            if (valid && !busy) mcnt = mcnt + 64'd1;
        end

        // Narrow counter: 15 retires reach all-ones, one more wraps to zero.
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RESET_W = 1'b1;
        wbus.WB_VALID = 1'b1;
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        chk("wrap_full", wbus.INSTRET_OUT, 64'hF);
        wbus.WB_VALID = 1'b0;
        wbus.REG_WRITE = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap_bubble", wbus.INSTRET_OUT, 64'hF);
        wbus.WB_VALID = 1'b1;
        wbus.REG_WRITE = 1'b0;
        wbus.BUSY_WAIT = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap_stall", wbus.INSTRET_OUT, 64'hF);
        wbus.BUSY_WAIT = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap_zero", wbus.INSTRET_OUT, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: the write-back stage of the 5-stage RISC-V pipeline.
- Selects the write-back value and commits it to the 32 x 32 integer register file.
- Provides two bypassed read ports to the ID stage and a write-back forwarding tap for the EX forwarding unit.
- Counts retired instructions for the instret CSR.

Parameters:
XLEN, 32, datapath and register width
NREGS, 32, number of architectural registers; register index width is log2(NREGS) = 5
CNT_W, 64, width of the retired-instruction counter

Ports:
CLK  in  1  system clock, rising-edge active
RESET  in  1  asynchronous, active-low reset
BUSY_WAIT  in  1  memory stall; when high, no state changes
WB_VALID  in  1  MEM/WB slot holds a real (non-bubble) instruction
REG_WRITE  in  1  instruction writes rd
MEM_TO_REG  in  2  write-back source select
IN_ADDRESS  in  5  rd index
ALU_RESULT  in  XLEN  EX result
DATA_READED  in  XLEN  load data, already extended
PC_NEXT  in  XLEN  PC+4, used for JAL/JALR link
RS1_ADDR  in  5  ID read port 1 index
RS2_ADDR  in  5  ID read port 2 index
RS1_DATA  out  XLEN  read port 1 data
RS2_DATA  out  XLEN  read port 2 data
WB_DATA_OUT  out  XLEN  selected write-back value (forwarding tap)
WB_EN_OUT  out  1  qualified write enable (forwarding tap)
WB_ADDR_OUT  out  5  equals IN_ADDRESS
INSTRET_OUT  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - RESET low asynchronously clears all NREGS registers and INSTRET_OUT to 0.
  - While RESET is low, the combinational outputs evaluate normally and read 0.
  - Deassertion takes effect at the next CLK edge.
- Write-back select (combinational) into WB_DATA_OUT:
  - MEM_TO_REG 00 selects ALU_RESULT.
  - 01 selects DATA_READED.
  - 10 selects PC_NEXT.
  - 11 is reserved and selects ALU_RESULT.
- Qualified enable: WB_EN_OUT = WB_VALID & REG_WRITE & !BUSY_WAIT & (IN_ADDRESS != 0).
- Write:
  - On a rising CLK edge with WB_EN_OUT high, reg[IN_ADDRESS] takes WB_DATA_OUT. Latency is one edge.
  - No write occurs when BUSY_WAIT is high, even if REG_WRITE is high.
  - The instruction stays in MEM/WB and is written when the stall clears.
- x0:
  - Writes to x0 are discarded.
  - Reads of x0 always return 0, regardless of bypass.
- Read ports:
  - Combinational, zero latency.
  - Write-through bypass: if WB_EN_OUT is high and RSn_ADDR == IN_ADDRESS != 0, RSn_DATA = WB_DATA_OUT; otherwise it returns reg[RSn_ADDR].
  - Both ports may bypass in the same cycle.
- Retire counter:
  - On a rising edge with WB_VALID & !BUSY_WAIT, INSTRET_OUT increments by 1, regardless of REG_WRITE.
  - Wraps modulo 2^CNT_W from all-ones to 0 with no flag.
  - Holds while BUSY_WAIT is high.
- Simultaneous events:
  - Reset wins over a write and over a counter increment in the same cycle.
  - A stall mid-instruction simply defers the commit by whole cycles; there is no partial write.
- No internal FSM beyond the register array and counter. All state is updated only on the CLK edge or asynchronous reset.

Decomposition:
- Shared package `rv_pipe_pkg`, holding:
  - the MEM_TO_REG encodings WB_SEL_ALU = 2'b00, WB_SEL_MEM = 2'b01, WB_SEL_PC = 2'b10;
  - XLEN and the register index width;
  - the x0 index constant.
- One natural sub-module, `regfile_2r1w`:
  - contains the storage array, asynchronous clear, and the two read ports with bypass;
  - the top level keeps the write-back mux, enable qualification and instret counter.

Test Plan:
- Reset: RESET low with REG_WRITE=1, IN_ADDRESS=5, ALU_RESULT=0xDEADBEEF for 3 edges -> RS1_ADDR=5 reads 0; INSTRET_OUT=0; after release, one edge writes x5=0xDEADBEEF.
- Mux: MEM_TO_REG 00/01/10/11 with ALU=0x11, MEM=0x22, PC=0x104, rd=7 on successive cycles -> x7 is 0x11, then 0x22, then 0x104, then 0x11; INSTRET_OUT increments by 4.
- Bypass: x3=0x5 stored; present a write of x3=0xAA with RS1_ADDR=RS2_ADDR=3 -> both ports show 0xAA before the edge and from register storage after it.
- x0: REG_WRITE=1, IN_ADDRESS=0, ALU_RESULT=0xFFFFFFFF, RS1_ADDR=0 -> RS1_DATA=0 before and after; WB_EN_OUT=0; INSTRET_OUT increments.
- Stall: BUSY_WAIT=1 for 4 edges with a write of x9=0x1234 pending -> x9 unchanged and INSTRET unchanged; after BUSY_WAIT drops, one edge sets x9=0x1234 and INSTRET+1.
- Bubble/wrap: WB_VALID=0 with REG_WRITE=1 -> no write and no count; INSTRET preloaded near wrap (CNT_W overridden to 4, value 0xF) plus one valid retire -> 0x0.
